// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL / core reset sequencer.
package pll_seq_pkg;

    // Sequencer states; encoding is binary, one-hot is not needed at this size.
    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        SETTLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } pll_state_t;

    // Registered output bundle, decoded purely from state.
    typedef struct packed {
        logic pll_rst;
        logic core_reset;
        logic ready;
        logic fail;
    } seq_out_t;

    // Width of the shared phase counter: large enough to hold the biggest
    // terminal count among the three timed phases.
    function automatic int cnt_w(input int rst_cycles,
                                 input int lock_timeout,
                                 input int stable_cycles);
        int m;
        m = rst_cycles;
        if (lock_timeout > m) begin
            m = lock_timeout;
        end
        if (stable_cycles > m) begin
            m = stable_cycles;
        end
        return $clog2(m + 1);
    endfunction

    // Output levels for each state; only RESET_PLL drives the PLL reset and
    // only RUN releases the core.
    function automatic seq_out_t decode_outputs(input pll_state_t s);
        seq_out_t o;
        o = '{pll_rst: 1'b0, core_reset: 1'b1, ready: 1'b0, fail: 1'b0};
        case (s)
            RESET_PLL: o.pll_rst = 1'b1;
            WAIT_LOCK: o.pll_rst = 1'b0;
            SETTLE:    o.pll_rst = 1'b0;
            RUN: begin
                o.core_reset = 1'b0;
                o.ready      = 1'b1;
            end
            FAIL:      o.fail = 1'b1;
            default: begin
                o.pll_rst    = 1'b1;
                o.core_reset = 1'b1;
            end
        endcase
        return o;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-stage single-bit synchronizer with asynchronous active-high reset to 0.
// Also used by the downstream per-domain reset synchronizers.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Capture the asynchronous input and let the first stage settle for a cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock-wait / core-release sequencer in the refclk domain.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   RESET_PLL | PLL held in reset for RST_CYCLES
//   WAIT_LOCK | PLL released, waiting up to LOCK_TIMEOUT for lock
//   SETTLE    | lock seen, must stay stable for STABLE_CYCLES
//   RUN       | core released, ready=1; lock loss restarts the sequence
//   FAIL      | retries exhausted; only soft_reset or rst leave it
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 7
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked,
    input  logic       soft_reset,
    output logic       pll_rst,
    output logic       core_reset,
    output logic       ready,
    output logic       fail,
    output logic [2:0] retry_count
);

    localparam int            CW          = cnt_w(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [2:0]    RETRY_MAX   = 3'(MAX_RETRIES);

    logic          locked_s;
    pll_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    retry_q, retry_d;
    seq_out_t      out_q, out_d;

    sync_2ff u_lock_sync (
        .clk_i (refclk),
        .rst_i (rst),
        .d_i   (locked),
        .q_o   (locked_s)
    );

    // Next-state, counter and retry logic; soft_reset overrides everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        retry_d = retry_q;

        case (state_q)
            RESET_PLL: begin
                if (cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            WAIT_LOCK: begin
                // Lock detection wins over a timeout landing in the same cycle.
                if (locked_s) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    cnt_d = '0;
                    if (retry_q == RETRY_MAX) begin
                        state_d = FAIL;
                    end else begin
                        state_d = RESET_PLL;
                        retry_d = retry_q + 3'd1;
                    end
                end
            end
            SETTLE: begin
                // A glitch drops back to waiting with a fresh timeout window,
                // without charging a retry.
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                cnt_d = '0;
                if (!locked_s) begin
                    state_d = RESET_PLL;
                    retry_d = '0;
                end
            end
            FAIL: begin
                cnt_d = '0;
            end
            default: begin
                state_d = RESET_PLL;
                cnt_d   = '0;
                retry_d = '0;
            end
        endcase

        if (soft_reset) begin
            state_d = RESET_PLL;
            cnt_d   = '0;
            retry_d = '0;
        end

        out_d = decode_outputs(state_d);
    end

    // State, counter, retry and registered output decode.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q <= RESET_PLL;
            cnt_q   <= '0;
            retry_q <= '0;
            out_q   <= decode_outputs(RESET_PLL);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            out_q   <= out_d;
        end
    end

    assign pll_rst     = out_q.pll_rst;
    assign core_reset  = out_q.core_reset;
    assign ready       = out_q.ready;
    assign fail        = out_q.fail;
    assign retry_count = retry_q;

endmodule
